// File: rtl/hfifo_sched_pkg.sv
// Shared types and helpers for the horizontal FIFO lane scheduler.
package hfifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MODE_W = 2;

  // Delay select of one lane for a given rotation phase: (lane + phase) mod 4.
  function automatic logic [MODE_W-1:0] lane_mode(input int unsigned lane,
                                                  input logic [MODE_W-1:0] phase);
    return MODE_W'(lane) + phase;
  endfunction

endpackage

// File: rtl/hfifo_valid_tap.sv
// Valid shift register plus per-lane tap select; mirrors the lane delay taps.
module hfifo_valid_tap
  import hfifo_sched_pkg::*;
#(
  parameter int unsigned DLY_STEP = 4,
  parameter int unsigned DEPTH    = 3 * DLY_STEP,
  parameter int unsigned LANES    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vin,
  input  logic [MODE_W*LANES-1:0]   mode,
  output logic [LANES-1:0]          out_valid
);

  logic [DEPTH-1:0] vsr_q;
  logic [DEPTH-1:0] vsr_d;

  // Shift the gated valid in every cycle.
  always_comb begin
    vsr_d = {vsr_q[DEPTH-2:0], vin};
  end

  // Valid history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_q <= '0;
    end else begin
      vsr_q <= vsr_d;
    end
  end

  // Pick each lane's valid from the tap that matches its delay select.
  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      case (mode[MODE_W*k +: MODE_W])
        2'd0:    out_valid[k] = vin;
        2'd1:    out_valid[k] = vsr_q[DLY_STEP-1];
        2'd2:    out_valid[k] = vsr_q[2*DLY_STEP-1];
        2'd3:    out_valid[k] = vsr_q[3*DLY_STEP-1];
        default: out_valid[k] = vin;
      endcase
    end
  end

endmodule

// File: rtl/horizontal_fifo_sched.sv
// Frame FSM, beat/segment counters and rotating lane delay selects.
module horizontal_fifo_sched
  import hfifo_sched_pkg::*;
#(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned DLY_STEP = 4,
  parameter int unsigned LANES    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         frame_len,
  input  logic [2:0]               seg_log2,
  input  logic                     in_valid,
  output logic [MODE_W*LANES-1:0]  mode,
  output logic [LANES-1:0]         out_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned DRAIN_LEN = 3 * DLY_STEP;
  localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [2:0]                seg_q, seg_d;
  logic [MODE_W-1:0]         phase_q, phase_d;
  logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
  logic [MODE_W*LANES-1:0]   mode_q, mode_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      gated_valid_s;
  logic [CNT_W-1:0]          seg_mask_s;
  logic                      seg_end_s;
  logic                      last_beat_s;

  // Beat qualifiers: only RUN beats count or enter the valid history.
  always_comb begin
    gated_valid_s = in_valid && (state_q == RUN);
    seg_mask_s    = (CNT_W'(1) << seg_q) - CNT_W'(1);
    seg_end_s     = ((beat_cnt_q & seg_mask_s) == seg_mask_s);
    last_beat_s   = (beat_cnt_q == (len_q - CNT_W'(1)));
  end

  // Next-state logic for FSM, counters, mode and status pulses.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    seg_d      = seg_q;
    phase_d    = phase_q;
    dcnt_d     = dcnt_q;
    err_d      = 1'b0;
    mode_d     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            err_d = 1'b1;
          end else begin
            len_d      = frame_len;
            seg_d      = seg_log2;
            beat_cnt_d = '0;
            phase_d    = '0;
            state_d    = RUN;
          end
        end else begin
          state_d = IDLE;
        end
        if (in_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
      end
      RUN: begin
        err_d = start;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (seg_end_s) begin
            phase_d = phase_q + MODE_W'(1);
          end else begin
            phase_d = phase_q;
          end
          if (last_beat_s) begin
            state_d = DRAIN;
            dcnt_d  = DCNT_W'(DRAIN_LEN - 1);
          end else begin
            state_d = RUN;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      DRAIN: begin
        err_d = start || in_valid;
        if (dcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      mode_d = '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        mode_d[MODE_W*k +: MODE_W] = lane_mode(k, phase_d);
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN) && (dcnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      seg_q      <= '0;
      phase_q    <= '0;
      dcnt_q     <= '0;
      mode_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      seg_q      <= seg_d;
      phase_q    <= phase_d;
      dcnt_q     <= dcnt_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  hfifo_valid_tap #(
    .DLY_STEP (DLY_STEP),
    .DEPTH    (3 * DLY_STEP),
    .LANES    (LANES)
  ) u_valid_tap (
    .clk       (clk),
    .rst_n     (rst_n),
    .vin       (gated_valid_s),
    .mode      (mode_q),
    .out_valid (out_valid)
  );

  assign mode = mode_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_horizontal_fifo_sched.sv
// Directed table-driven bench for horizontal_fifo_sched.
module tb_horizontal_fifo_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] frame_len;
  logic [2:0] seg_log2;
  logic       in_valid;
  logic [7:0] mode;
  logic [3:0] out_valid;
  logic       busy;
  logic       done;
  logic       err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       start;
    logic [9:0] frame_len;
    logic [2:0] seg_log2;
    logic       in_valid;
    logic       exp_run;
    logic [7:0] exp_mode;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vec_q[$];
  bit   ghist[$];
  logic [7:0] modes_tbl [4];

  horizontal_fifo_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .seg_log2  (seg_log2),
    .in_valid  (in_valid),
    .mode      (mode),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic st, input int len, input int seg, input logic iv,
                     input logic run, input logic [7:0] m, input logic b,
                     input logic d, input logic e);
    vec_t v;
    v.start = st; v.frame_len = 10'(len); v.seg_log2 = 3'(seg); v.in_valid = iv;
    v.exp_run = run; v.exp_mode = m; v.exp_busy = b; v.exp_done = d; v.exp_err = e;
    vec_q.push_back(v);
  endtask

  task automatic idle_rows(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Apply queued rows; each row is driven after a rising edge and checked at the falling edge.
  task automatic run_table(input string tag);
    vec_t v;
    bit   g;
    int   n;
    int   m;
    logic [3:0] exp_ov;
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      start = v.start; frame_len = v.frame_len; seg_log2 = v.seg_log2; in_valid = v.in_valid;
      g = v.in_valid & v.exp_run;
      n = ghist.size();
      for (int k = 0; k < 4; k++) begin
        m = int'(v.exp_mode[2*k +: 2]);
        if (m == 0) exp_ov[k] = g;
        else if (n >= 4*m) exp_ov[k] = ghist[n - 4*m];
        else exp_ov[k] = 1'b0;
      end
      ghist.push_back(g);
      @(negedge clk);
      check($sformatf("%s[%0d] mode", tag, i), 32'(mode), 32'(v.exp_mode));
      check($sformatf("%s[%0d] out_valid", tag, i), 32'(out_valid), 32'(exp_ov));
      check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(v.exp_busy));
      check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(v.exp_done));
      check($sformatf("%s[%0d] err", tag, i), 32'(err), 32'(v.exp_err));
      @(posedge clk);
      #1;
    end
    vec_q.delete();
    start = 1'b0; in_valid = 1'b0; frame_len = 10'd0; seg_log2 = 3'd0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " mode"}, 32'(mode), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " done"}, 32'(done), 32'h0);
    check({tag, " err"}, 32'(err), 32'h0);
  endtask

  task automatic do_reset();
    start = 1'b0; in_valid = 1'b0; frame_len = 10'd0; seg_log2 = 3'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ghist.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    modes_tbl[0] = 8'hE4; modes_tbl[1] = 8'h39; modes_tbl[2] = 8'h4E; modes_tbl[3] = 8'h93;
    rst_n = 1'b0;

    // Reset state and idle cycles.
    do_reset();
    idle_rows(3);
    run_table("idle");

    // Continuous 16-beat frame, 4-beat segments.
    add(1'b1, 16, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 16; b++) add(1'b0, 0, 0, 1'b1, 1'b1, modes_tbl[b/4], 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 12; d++) add(1'b0, 0, 0, 1'b0, 1'b0, 8'hE4, 1'b1, d == 11, 1'b0);
    idle_rows(1);
    run_table("cont");

    // Same frame with in_valid toggling: phase follows accepted beats only.
    add(1'b1, 16, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c < 32; c++) add(1'b0, 0, 0, c % 2 == 1, 1'b1, modes_tbl[(c/2)/4], 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 12; d++) add(1'b0, 0, 0, 1'b0, 1'b0, 8'hE4, 1'b1, d == 11, 1'b0);
    idle_rows(1);
    run_table("toggle");

    // Protocol violations: in_valid in IDLE, zero-length start, start in RUN/DRAIN/done.
    add(1'b0, 0, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 4, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b1, 1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4, 1, 1'b1, 1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b1, 1'b1, 8'h39, 1'b1, 1'b0, 1'b1);
    add(1'b0, 0, 0, 1'b1, 1'b1, 8'h39, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4, 1, 1'b0, 1'b0, 8'h4E, 1'b1, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b0, 1'b0, 8'h4E, 1'b1, 1'b0, 1'b1);
    add(1'b0, 0, 0, 1'b1, 1'b0, 8'h4E, 1'b1, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b0, 1'b0, 8'h4E, 1'b1, 1'b0, 1'b1);
    for (int d = 4; d < 11; d++) add(1'b0, 0, 0, 1'b0, 1'b0, 8'h4E, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4, 1, 1'b0, 1'b0, 8'h4E, 1'b1, 1'b1, 1'b0);
    add(1'b0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle_rows(1);
    run_table("err");

    // Reset in the middle of a 16-beat frame, at beat 7.
    add(1'b1, 16, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 7; b++) add(1'b0, 0, 0, 1'b1, 1'b1, modes_tbl[b/4], 1'b1, 1'b0, 1'b0);
    run_table("pre_rst");
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ghist.delete();
    @(posedge clk);
    #1;
    idle_rows(16);
    run_table("post_rst");

    // One-beat frame with one-beat segments: phase wraps to 1, then full drain.
    add(1'b1, 1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 0, 0, 1'b1, 1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 12; d++) add(1'b0, 0, 0, 1'b0, 1'b0, 8'h39, 1'b1, d == 11, 1'b0);
    idle_rows(2);
    run_table("len1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
